// File: rtl/key_event_gen.sv
// key_event_gen: debounces the raw HID keycode and turns it into one-cycle
// press/release pulses, a held-key level, and optional menu auto-repeat.
// Press pulses carry the keycode; release pulses carry keycode 0.
module key_event_gen #(
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode_raw,
    input  logic       enable,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       key_release,
    output logic [7:0] key_held
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // The timer only ever needs to reach max(delay, period) - 1.
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'((REPEAT_DELAY  > 0) ? REPEAT_DELAY  - 1 : 0);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    logic [7:0]       r_raw_q;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_key_held;

    state_t           r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;

    logic [7:0]       r_keycode, w_keycode_nxt;
    logic             r_valid,   w_valid_nxt;
    logic             r_release, w_release_nxt;

    logic             w_commit;
    logic             w_rep_due;

    // A candidate that has been stable long enough and differs from the held key.
    assign w_commit = (r_raw_q == r_cand) && (r_cnt == CNT_MAX) && (r_cand != r_key_held);

    // A repeat is due on the last timer count of either waiting state.
    assign w_rep_due = ((r_state == S_DELAY)  && (r_timer == DLY_LAST)) ||
                       ((r_state == S_REPEAT) && (r_timer == PER_LAST));

    // Input register and debounce: restart the count whenever the raw value moves.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_raw_q    <= '0;
            r_cand     <= '0;
            r_cnt      <= '0;
            r_key_held <= '0;
        end else begin
            r_raw_q <= keycode_raw;
            if (r_raw_q != r_cand) begin
                r_cand <= r_raw_q;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_commit) begin
                r_key_held <= r_cand;
            end
        end
    end

    // Repeat FSM state and timer register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Repeat FSM next state: any commit restarts the delay, a commit to 0 idles.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (REPEAT_DELAY == 0) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
        end else if (w_commit) begin
            w_state_nxt = (r_cand != 8'd0) ? S_DELAY : S_IDLE;
            w_timer_nxt = '0;
        end else if (r_key_held == 8'd0) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                S_DELAY: begin
                    if (r_timer == DLY_LAST) begin
                        w_state_nxt = S_REPEAT;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (r_timer == PER_LAST) w_timer_nxt = '0;
                    else                     w_timer_nxt = r_timer + 1'b1;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // Next pulse values: a commit overrides a coincident repeat; enable gates all pulses.
    always_comb begin
        w_keycode_nxt = '0;
        w_valid_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (w_commit) begin
            if (r_cand != 8'd0) begin
                w_keycode_nxt = r_cand;
                w_valid_nxt   = 1'b1;
            end else begin
                w_release_nxt = 1'b1;
            end
        end else if (w_rep_due && (REPEAT_DELAY != 0)) begin
            w_keycode_nxt = r_key_held;
            w_valid_nxt   = 1'b1;
        end
        if (!enable) begin
            w_keycode_nxt = '0;
            w_valid_nxt   = 1'b0;
            w_release_nxt = 1'b0;
        end
    end

    // Registered pulse outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_keycode <= '0;
            r_valid   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_keycode <= w_keycode_nxt;
            r_valid   <= w_valid_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign keycode     = r_keycode;
    assign key_valid   = r_valid;
    assign key_release = r_release;
    assign key_held    = r_key_held;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen: expected events are queued when stimulus
// is applied and matched against observed pulses at the falling edge.
module tb_key_event_gen;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode_raw;
    logic       enable;
    logic [7:0] keycode;
    logic       key_valid;
    logic       key_release;
    logic [7:0] key_held;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    typedef struct {
        int         c;
        bit         rel;
        logic [7:0] key;
    } ev_t;

    ev_t q[$];
    ev_t e;

    key_event_gen #(
        .STABLE_CYCLES(4),
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .keycode_raw(keycode_raw),
        .enable     (enable),
        .keycode    (keycode),
        .key_valid  (key_valid),
        .key_release(key_release),
        .key_held   (key_held)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic void push(input int c, input bit rel, input logic [7:0] key);
        ev_t n;
        n.c = c; n.rel = rel; n.key = key;
        q.push_back(n);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Bounded wait for all queued events to be observed.
    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge Clk);
        chk(tag, q.size(), 0);
    endtask

    // Scoreboard monitor: every pulse must match the oldest queued event.
    always @(negedge Clk) begin
        if (Reset) begin
            if (!key_valid) chk("keycode_idle_zero", keycode, 0);
            if (key_valid || key_release) begin
                chk("valid_release_exclusive", key_valid & key_release, 0);
                if (q.size() == 0) begin
                    chk("unexpected_event", {22'd0, key_valid, key_release, keycode}, 0);
                end else begin
                    e = q.pop_front();
                    chk("event_cycle", cyc, e.c);
                    chk("event_is_release", key_release, e.rel);
                    chk("event_is_press", key_valid, !e.rel);
                    chk("event_keycode", keycode, e.rel ? 8'd0 : e.key);
                end
            end
        end
    end

    initial begin
        int t;
        // Reset with a key already on the raw input.
        Reset = 1'b0; keycode_raw = 8'd30; enable = 1'b1;
        step(3);
        chk("rst_keycode", keycode, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_release", key_release, 0);
        chk("rst_held", key_held, 0);
        t = cyc;
        Reset = 1'b1;
        push(t + 6, 0, 8'd30);
        step(7);
        chk("rst_press_held", key_held, 30);
        step(1);
        // Release lands on the same cycle the first repeat would: release only.
        keycode_raw = 8'd0;
        push(t + 14, 1, 8'd0);
        step(8);
        chk("rst_release_held", key_held, 0);
        drain("reset_phase_drain");

        // Press, auto-repeat, release.
        step(2);
        t = cyc;
        keycode_raw = 8'd31;
        push(t + 6, 0, 8'd31);
        push(t + 14, 0, 8'd31);
        push(t + 18, 0, 8'd31);
        push(t + 22, 0, 8'd31);
        push(t + 26, 1, 8'd0);
        step(7);
        chk("press_held", key_held, 31);
        step(13);
        keycode_raw = 8'd0;
        step(8);
        chk("release_held", key_held, 0);
        drain("press_phase_drain");

        // Bounce shorter than the stable window.
        for (int i = 0; i < 10; i++) begin
            keycode_raw = (i % 2 == 0) ? 8'd40 : 8'd0;
            step(2);
            chk("bounce_held", key_held, 0);
        end
        keycode_raw = 8'd0;
        step(10);
        chk("bounce_settled_held", key_held, 0);

        // Direct A->B change; repeat timer restarts on the B commit.
        t = cyc;
        keycode_raw = 8'd30;
        push(t + 6, 0, 8'd30);
        push(t + 14, 0, 8'd30);
        push(t + 16, 0, 8'd8);
        push(t + 24, 0, 8'd8);
        push(t + 28, 0, 8'd8);
        push(t + 32, 0, 8'd8);
        push(t + 35, 1, 8'd0);
        step(10);
        keycode_raw = 8'd8;
        step(7);
        chk("ab_held", key_held, 8);
        step(12);
        keycode_raw = 8'd0;
        drain("ab_phase_drain");
        step(2);
        chk("ab_final_held", key_held, 0);

        // Enable gating: commit is silent, the scheduled repeat still fires.
        step(2);
        t = cyc;
        enable = 1'b0;
        keycode_raw = 8'd40;
        step(10);
        chk("gated_held", key_held, 40);
        enable = 1'b1;
        push(t + 14, 0, 8'd40);
        push(t + 18, 0, 8'd40);
        step(8);

        // Reset while a repeat pulse is on the outputs.
        #1;
        Reset = 1'b0;
        keycode_raw = 8'd0;
        #1;
        chk("midrst_keycode", keycode, 0);
        chk("midrst_valid", key_valid, 0);
        chk("midrst_release", key_release, 0);
        chk("midrst_held", key_held, 0);
        step(3);
        Reset = 1'b1;
        step(20);
        chk("post_rst_held", key_held, 0);
        chk("post_rst_queue", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
